// File: rtl/tt_um_blink_breathe.sv
// tt_um_blink_breathe: breathing-LED controller fed by a 16-bit upstream blink counter.
// A duty ramp (UP -> HOLD_HI -> DOWN -> HOLD_LO) advances once per change of the
// counter's high byte; a PWM comparator uses the low byte as its phase reference.
// A watchdog flags a stalled upstream counter.
//
// Optional feature macro: BREATHE_GAMMA_EN (defined: PWM uses (duty*duty)>>8).
//
// Ports:
//   clk      - clock, shared with the upstream counter tile
//   rst_n    - asynchronous active-low reset
//   ena      - freezes all state except the input capture flops when low
//   ui_in    - upstream count[15:8]
//   uio_in   - upstream count[7:0]
//   uo_out   - [0] pwm_a, [1] pwm_b, [3:2] state, [4] tick, [5] stall, [7:6] duty[7:6]
//   uio_out  - constant 0x00
//   uio_oe   - constant 0x00 (bidirectional pins are inputs)
module tt_um_blink_breathe #(
    parameter int unsigned STEP       = 4,
    parameter int unsigned HOLD_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned DUTY_W = 8;
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned WD_W   = 10;

    localparam logic [1:0] ST_UP      = 2'd0;
    localparam logic [1:0] ST_HOLD_HI = 2'd1;
    localparam logic [1:0] ST_DOWN    = 2'd2;
    localparam logic [1:0] ST_HOLD_LO = 2'd3;

    localparam logic [DUTY_W-1:0] STEP_B    = DUTY_W'(STEP);
    localparam logic [DUTY_W-1:0] UP_LIMIT  = DUTY_W'(255 - STEP);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [WD_W-1:0]   WD_MAX    = {WD_W{1'b1}};

    logic [7:0]        hi_q;
    logic [7:0]        hi_d;
    logic [7:0]        lo_q;
    logic [1:0]        prime_q;
    logic              tick_q;
    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [DUTY_W-1:0] duty;
    logic [DUTY_W-1:0] duty_nx;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nx;
    logic [WD_W-1:0]   wd;
    logic [WD_W-1:0]   wd_nx;
    logic              pwm_a_q;
    logic              pwm_b_q;
    logic              tick_c;
    logic [DUTY_W-1:0] eff_c;

    // First captured byte after reset compares against the reset value of hi_d;
    // the priming pipeline keeps that artefact from producing a tick.
    assign tick_c = prime_q[1] & (hi_q != hi_d) & ena;

`ifdef BREATHE_GAMMA_EN
    logic [2*DUTY_W-1:0] duty_sq_c;
    assign duty_sq_c = (2*DUTY_W)'(duty) * (2*DUTY_W)'(duty);
    assign eff_c     = duty_sq_c[2*DUTY_W-1:DUTY_W];
`else
    assign eff_c = duty;
`endif

    // Input capture and tick pulse: run every cycle regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q    <= '0;
            hi_d    <= '0;
            lo_q    <= '0;
            prime_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            hi_q    <= ui_in;
            hi_d    <= hi_q;
            lo_q    <= uio_in;
            prime_q <= {prime_q[0], 1'b1};
            tick_q  <= tick_c;
        end
    end

    // Ramp FSM, watchdog and PWM registers; all frozen while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_UP;
            duty    <= '0;
            hold    <= '0;
            wd      <= '0;
            pwm_a_q <= 1'b0;
            pwm_b_q <= 1'b0;
        end else if (ena) begin
            state   <= state_nx;
            duty    <= duty_nx;
            hold    <= hold_nx;
            wd      <= wd_nx;
            pwm_a_q <= (lo_q < eff_c);
            pwm_b_q <= (lo_q < ~eff_c);
        end
    end

    // Next-state logic for the duty ramp; compares are arranged so no wrap occurs.
    always_comb begin
        state_nx = state;
        duty_nx  = duty;
        hold_nx  = hold;
        if (tick_c) begin
            case (state)
                ST_UP: begin
                    if (duty > UP_LIMIT) begin
                        duty_nx  = '1;
                        state_nx = ST_HOLD_HI;
                        hold_nx  = '0;
                    end else begin
                        duty_nx = duty + STEP_B;
                    end
                end
                ST_HOLD_HI: begin
                    if (hold == HOLD_LAST) begin
                        state_nx = ST_DOWN;
                        hold_nx  = '0;
                    end else begin
                        hold_nx = hold + HOLD_W'(1);
                    end
                end
                ST_DOWN: begin
                    if (duty < STEP_B) begin
                        duty_nx  = '0;
                        state_nx = ST_HOLD_LO;
                        hold_nx  = '0;
                    end else begin
                        duty_nx = duty - STEP_B;
                    end
                end
                default: begin
                    if (hold == HOLD_LAST) begin
                        state_nx = ST_UP;
                        hold_nx  = '0;
                    end else begin
                        hold_nx = hold + HOLD_W'(1);
                    end
                end
            endcase
        end
    end

    // Watchdog: a tick always wins over saturation.
    always_comb begin
        wd_nx = wd;
        if (tick_c) begin
            wd_nx = '0;
        end else if (wd != WD_MAX) begin
            wd_nx = wd + WD_W'(1);
        end
    end

    assign uo_out  = {duty[7:6], wd[WD_W-1], tick_q, state, pwm_b_q, pwm_a_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_blink_breathe.sv
// Scoreboard bench for tt_um_blink_breathe: the stimulus side steps a reference
// model (closed-form ramp position from the tick count) and queues the expected
// uo_out for every clock edge; a monitor pops and compares after each edge.
module tb_tt_um_blink_breathe;

    localparam int STEP = 4;
    localparam int HOLD = 16;
    localparam int M    = (255 - STEP) / STEP + 1;   // additive steps in a ramp
    localparam int U    = M + 1;                      // ticks spent in a ramp state
    localparam int PER  = 2 * U + 2 * HOLD;           // ticks per breathing period

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_blink_breathe #(.STEP(STEP), .HOLD_TICKS(HOLD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_duty(input int k);
        int p;
        p = k % PER;
        if (p < U)                 return 8'(STEP * p);
        else if (p < U + HOLD)     return 8'd255;
        else if (p < 2 * U + HOLD) return 8'(255 - STEP * (p - U - HOLD));
        else                       return 8'd0;
    endfunction

    function automatic logic [1:0] ref_state(input int k);
        int p;
        p = k % PER;
        if (p < U)                 return 2'd0;
        else if (p < U + HOLD)     return 2'd1;
        else if (p < 2 * U + HOLD) return 2'd2;
        else                       return 2'd3;
    endfunction

    function automatic logic [7:0] ref_eff(input logic [7:0] d);
`ifdef BREATHE_GAMMA_EN
        int sq;
        sq = int'(d) * int'(d);
        return 8'(sq / 256);
`else
        return d;
`endif
    endfunction

    logic [7:0] m_hi, m_hd, m_lo;
    int         m_edges, m_k, m_since;
    logic       m_pa, m_pb;
    logic [7:0] exp_q[$];

    task automatic model_reset();
        m_hi = 8'h00; m_hd = 8'h00; m_lo = 8'h00;
        m_edges = 0; m_k = 0; m_since = 0;
        m_pa = 1'b0; m_pb = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge with the given inputs applied beforehand.
    task automatic model_edge(input logic [7:0] ui, input logic [7:0] uio, input logic en);
        logic       tk;
        logic [7:0] e, ne, d;
        tk = en && (m_edges >= 2) && (m_hi != m_hd);
        if (en) begin
            e    = ref_eff(ref_duty(m_k));
            ne   = ~e;
            m_pa = (m_lo < e);
            m_pb = (m_lo < ne);
        end
        if (tk) begin
            m_k++;
            m_since = 0;
        end else if (en && m_since < 1023) begin
            m_since++;
        end
        m_hd = m_hi;
        m_hi = ui;
        m_lo = uio;
        m_edges++;
        d = ref_duty(m_k);
        exp_q.push_back({d[7:6], (m_since >= 512), tk, ref_state(m_k), m_pb, m_pa});
    endtask

    // ---------------- stimulus helpers ----------------
    logic [15:0] cnt = 16'h0000;

    task automatic apply(input logic [7:0] ui, input logic [7:0] uio, input logic en);
        ui_in  = ui;
        uio_in = uio;
        ena    = en;
        model_edge(ui, uio, en);
    endtask

    task automatic drive(input logic [7:0] ui, input logic [7:0] uio, input logic en);
        @(negedge clk);
        apply(ui, uio, en);
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset mid-cycle, then a release with a stable high byte.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n  = 1'b0;
        ui_in  = 8'($urandom);
        uio_in = 8'($urandom);
        ena    = 1'($urandom);
        model_reset();
        #1;
        check("async_reset_uo_out", 32'(uo_out), 32'h0);
        repeat (3) begin
            @(negedge clk);
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
            ena    = 1'($urandom);
            sample();
            check("reset_uo_out", 32'(uo_out), 32'h0);
            check("reset_uio_out", 32'(uio_out), 32'h0);
            check("reset_uio_oe", 32'(uio_oe), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(cnt[15:8], 8'($urandom), 1'b1);
        repeat (3) drive(cnt[15:8], 8'($urandom), 1'b1);
    endtask

    task automatic run_to_tick(input int target);
        for (int c = 0; c < 6000 && m_k < target; c++) begin
            cnt = cnt + 16'd16;
            drive(cnt[15:8], cnt[7:0], 1'b1);
        end
    endtask

    // Sweep the low byte through all 256 values with the high byte frozen.
    task automatic pwm_sweep(input string tag);
        int         na, nb, ea, eb;
        logic [7:0] e, ne, hi;
        hi = m_hi;
        drive(hi, 8'h00, 1'b1);
        drive(hi, 8'h00, 1'b1);
        e  = ref_eff(ref_duty(m_k));
        ne = ~e;
        ea = 0; eb = 0;
        for (int v = 0; v < 256; v++) begin
            if (v < int'(e))  ea++;
            if (v < int'(ne)) eb++;
        end
        na = 0; nb = 0;
        for (int j = 0; j < 257; j++) begin
            drive(hi, 8'(j), 1'b1);
            sample();
            if (j >= 1) begin
                na += int'(uo_out[0]);
                nb += int'(uo_out[1]);
            end
        end
        check({tag, "_pwm_a_count"}, 32'(na), 32'(ea));
        check({tag, "_pwm_b_count"}, 32'(nb), 32'(eb));
    endtask

    // ---------------- monitor ----------------
    logic [7:0] mon_exp;
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check("uo_out", 32'(uo_out), 32'(mon_exp));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", n_err);
        $fatal(1, "timeout");
    end

    // ---------------- test sequence ----------------
    initial begin
        int stall_at, ticks_seen;
        logic [7:0] d;
        model_reset();
        #1 rst_n = 1'b0;

        // Reset and ramp through one breathing period.
        cnt = 16'h0000;
        do_reset();
        run_to_tick(32);
        sample();
        pwm_sweep("duty128");
        run_to_tick(64);
        sample();
        check("ramp_hold_hi", 32'({uo_out[7:6], uo_out[3:2]}), 32'h0000000D);
        pwm_sweep("duty255");
        run_to_tick(80);
        sample();
        check("ramp_down", 32'({uo_out[7:6], uo_out[3:2]}), 32'h0000000E);
        run_to_tick(144);
        sample();
        check("ramp_hold_lo", 32'({uo_out[7:6], uo_out[3:2]}), 32'h00000003);

        // Stall watchdog with the high byte frozen at 0x12.
        do_reset();
        repeat (4) drive(8'h11, 8'($urandom), 1'b1);
        stall_at = -1;
        for (int j = 0; j < 600; j++) begin
            drive(8'h12, 8'($urandom), 1'b1);
            sample();
            if (j == 1) check("stall_setup_tick", 32'(uo_out[4]), 32'h1);
            if (stall_at < 0 && uo_out[5]) stall_at = j;
        end
        check("stall_rise_edge", 32'(stall_at), 32'(1 + 512));
        drive(8'h13, 8'($urandom), 1'b1);
        drive(8'h13, 8'($urandom), 1'b1);
        sample();
        check("stall_clear_tick", 32'(uo_out[4]), 32'h1);
        check("stall_clear", 32'(uo_out[5]), 32'h0);

        // ena low for 1000 cycles during UP at duty 40.
        cnt = 16'h2000;
        do_reset();
        run_to_tick(10);
        ticks_seen = 0;
        for (int j = 0; j < 1000; j++) begin
            cnt = cnt + 16'd16;
            drive(cnt[15:8], cnt[7:0], 1'b0);
            sample();
            ticks_seen += int'(uo_out[4]);
        end
        d = ref_duty(10);
        check("ena_frozen_ticks", 32'(ticks_seen), 32'h0);
        check("ena_frozen_hold", 32'({uo_out[7:5], uo_out[3:2]}), 32'({d[7:6], 1'b0, ref_state(10)}));
        repeat (2) drive(cnt[15:8], cnt[7:0], 1'b0);
        ticks_seen = 0;
        for (int j = 0; j < 200 && m_k < 11; j++) begin
            cnt = cnt + 16'd16;
            drive(cnt[15:8], cnt[7:0], 1'b1);
            sample();
            ticks_seen += int'(uo_out[4]);
        end
        check("ena_resume_tick", 32'(ticks_seen), 32'h1);
        check("ena_resume_state", 32'(uo_out[3:2]), 32'(ref_state(11)));

        // Randomized run: variable counter rate, ena toggling, occasional reset.
        for (int j = 0; j < 5000; j++) begin
            logic en;
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end
            en = ena;
            if ($urandom_range(0, 99) < 4) en = ~en;
            if (en && !ena && (m_hi != m_hd)) en = 1'b0;
            if ($urandom_range(0, 9) != 0) cnt = cnt + 16'($urandom_range(0, 40));
            drive(cnt[15:8], cnt[7:0], en);
        end

        repeat (3) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
